// File: rtl/fifo_wr_stream_if.sv
// Write-side ingress adapter for the dual-clock FIFO (wclk domain): a 2-entry skid
// buffer in front of winc/wdata, plus a conservative fill level and a stall counter.
module fifo_wr_stream_if #(
  parameter int DSIZE        = 8,
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  input  logic [DSIZE-1:0]    s_data,
  output logic                s_ready,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  input  logic                stall_clr,
  output logic [15:0]         stall_cnt
);

  // Handshake: a word moves upstream->adapter when s_valid & s_ready at a wclk edge;
  // s_ready is a flop so it never sees wfull or s_valid combinationally.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  localparam logic [ADDRSIZE:0] AFULL_LVL = AFULL_THRESH[ADDRSIZE:0];

  state_t             state_q, state_d;
  logic [DSIZE-1:0]   head_q, head_d;
  logic [DSIZE-1:0]   skid_q, skid_d;
  logic               s_ready_q, s_ready_d;
  logic [ADDRSIZE:0]  wlevel_q, level_next;
  logic               walmost_full_q, walmost_full_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic               push, pop;

  function automatic logic [ADDRSIZE:0] g2b(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign pop  = (state_q != EMPTY) & ~wfull;
  assign push = s_valid & s_ready_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = s_data;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          skid_d  = s_data;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_d = s_data;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    s_ready_d = (state_d != TWO);
  end

  // Modulo subtract of binary pointers handles wrap; lagging rptr keeps it conservative.
  always_comb begin
    level_next     = g2b(wptr) - g2b(wq2_rptr);
    walmost_full_d = (level_next >= AFULL_LVL);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)
      stall_cnt_d = '0;
    else if (s_valid && !s_ready_q && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q        <= EMPTY;
      head_q         <= '0;
      skid_q         <= '0;
      s_ready_q      <= 1'b0;
      wlevel_q       <= '0;
      walmost_full_q <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      skid_q         <= skid_d;
      s_ready_q      <= s_ready_d;
      wlevel_q       <= level_next;
      walmost_full_q <= walmost_full_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign winc         = pop;
  assign wdata        = head_q;
  assign wlevel       = wlevel_q;
  assign walmost_full = walmost_full_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_stream_if.sv
// Bench for fifo_wr_stream_if: occupancy-count reference model with an expected-word
// queue, a pointer/level vector table, and hand sequences for stall and reset corners.
module tb_fifo_wr_stream_if;

  localparam int W = 8;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          s_valid;
  logic [W-1:0]  s_data;
  logic          s_ready;
  logic          wfull;
  logic [4:0]    wptr;
  logic [4:0]    wq2_rptr;
  logic          winc;
  logic [W-1:0]  wdata;
  logic [4:0]    wlevel;
  logic          walmost_full;
  logic          stall_clr;
  logic [15:0]   stall_cnt;

  fifo_wr_stream_if #(.DSIZE(8), .ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr), .winc(winc), .wdata(wdata),
    .wlevel(wlevel), .walmost_full(walmost_full), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  always #5 wclk = ~wclk;

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];   // words accepted by the adapter, not yet written
  logic         m_ready;
  int           m_stall;
  int           n_vec, n_fail;
  int           n_acc, n_dut_winc;

  typedef struct {
    int   wb;
    int   rb;
    int   exp_level;
    logic exp_af;
  } lvl_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ready = 1'b0;
    m_stall = 0;
  endtask

  // Called just after a rising edge; checks outputs mid-cycle, then advances the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic wf,
                       input logic clr, output logic acc);
    logic m_winc, push;
    s_valid = v; s_data = d; wfull = wf; stall_clr = clr;
    @(negedge wclk);
    m_winc = (exp_q.size() > 0) && !wf;
    chk("s_ready", s_ready, m_ready);
    chk("winc", winc, m_winc);
    chk("stall_cnt", stall_cnt, m_stall);
    if (winc === 1'b1) begin
      n_dut_winc++;
      if (exp_q.size() > 0) chk("wdata", wdata, exp_q[0]);
    end
    push = v & m_ready;
    @(posedge wclk); #1;
    if (m_winc) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(d);
      n_acc++;
    end
    if (clr) m_stall = 0;
    else if (v && !m_ready && m_stall < 65535) m_stall++;
    m_ready = (exp_q.size() < 2);
    acc = push;
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lvl_vec_t lv[9];
    logic acc;
    int idx, cyc;

    lv[0] = '{3, 29, 6, 1'b0};
    lv[1] = '{12, 0, 12, 1'b1};
    lv[2] = '{0, 0, 0, 1'b0};
    lv[3] = '{16, 0, 16, 1'b1};
    lv[4] = '{11, 0, 11, 1'b0};
    lv[5] = '{5, 21, 16, 1'b1};
    lv[6] = '{31, 31, 0, 1'b0};
    lv[7] = '{2, 30, 4, 1'b0};
    lv[8] = '{20, 8, 12, 1'b1};

    n_vec = 0; n_fail = 0; n_acc = 0; n_dut_winc = 0;
    wrst_n = 1'b0; s_valid = 1'b0; s_data = '0; wfull = 1'b0;
    wptr = '0; wq2_rptr = '0; stall_clr = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_walmost_full", walmost_full, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;

    // 1: continuous stream 0..15, wfull low
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 100) begin
      cycle(1'b1, W'(idx), 1'b0, 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    drain(4);

    // 2: wfull held while offering 5 words; two get buffered, then release
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, W'(100 + idx), 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    cyc = 0;
    while (idx < 5 && cyc < 50) begin
      cycle(1'b1, W'(100 + idx), 1'b0, 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    drain(4);

    // 3: random valid, wfull toggling, 1000 words
    idx = 0; cyc = 0;
    while (idx < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom), cyc[1], 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    drain(4);
    chk("no_loss_count", n_dut_winc, n_acc);

    // 4: level / almost-full table
    s_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wptr = gray(lv[i].wb);
      wq2_rptr = gray(lv[i].rb);
      @(posedge wclk); #1;
      chk($sformatf("wlevel[%0d]", i), wlevel, lv[i].exp_level);
      chk($sformatf("walmost_full[%0d]", i), walmost_full, lv[i].exp_af);
    end
    wptr = '0; wq2_rptr = '0;
    @(posedge wclk); #1;

    // 5: stall counter saturation and clear-with-stall
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(50 + i), 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h77, 1'b1, 1'b1, acc);
    stall_clr = 1'b0;
    repeat (65540) @(posedge wclk);
    #1;
    m_stall = 65535;
    cycle(1'b1, 8'h77, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h77, 1'b1, 1'b1, acc);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, acc);

    // 6: asynchronous reset while two words are held
    wptr = gray(5);
    @(posedge wclk); #1;
    wfull = 1'b0;
    #2;
    chk("pre_rst_winc", winc, 1);
    chk("pre_rst_wlevel", wlevel, 5);
    wrst_n = 1'b0;
    #1;
    chk("async_rst_s_ready", s_ready, 0);
    chk("async_rst_winc", winc, 0);
    chk("async_rst_wdata", wdata, 0);
    chk("async_rst_wlevel", wlevel, 0);
    chk("async_rst_walmost_full", walmost_full, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
    model_reset();
    s_valid = 1'b0; wptr = '0;
    n_acc = 0; n_dut_winc = 0;
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 50) begin
      cycle(1'b1, W'(200 + idx), 1'(cyc == 3), 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    drain(4);
    chk("post_rst_count", n_dut_winc, n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
